// File: rtl/psram_line_fetch.sv
// psram_line_fetch: fetches video lines from PSRAM as row-bounded bursts into a line FIFO
module psram_line_fetch #(
  parameter int          LINE_WORDS = 800,
  parameter logic [22:0] BASE_ADDR  = 23'h000000,
  parameter int          ROW_WORDS  = 128,
  parameter int          FIFO_DEPTH = 512
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        pix_empty,
  output logic        line_busy,
  output logic        underflow,
  output logic        overrun,
  input  logic        app_ctrlr_good,
  output logic        app_rd,
  output logic [22:0] app_addr,
  output logic        app_burst_op,
  input  logic        app_op_begun,
  input  logic        app_data_ok,
  input  logic        op_finished,
  input  logic [15:0] app_data_out
);
  localparam int RB = $clog2(ROW_WORDS);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SPACE, ISSUE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [22:0] acc;
  logic [11:0] remaining;
  logic [12:0] blen, bcnt, blen_c, row_left, free;
  logic phase, flush, load, start, cap, pop;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [15:0] mem [FIFO_DEPTH];
  assign row_left     = 13'(ROW_WORDS) - 13'(acc[RB-1:0]);
  assign blen_c       = ({1'b0, remaining} < row_left) ? {1'b0, remaining} : row_left;
  assign free         = 13'(FIFO_DEPTH) - 13'(count);
  assign pop          = pix_rd && count != '0;
  assign pix_empty    = count == '0;
  assign line_busy    = state != IDLE;
  assign app_rd       = state == ISSUE;
  assign app_burst_op = state == READ && bcnt < blen;
  always_comb begin
    state_n = state;
    flush   = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        flush = frame_start;
        start = !frame_start && line_start && app_ctrlr_good;
        state_n = start ? SPACE : IDLE;
      end
      SPACE: begin
        flush = frame_start;
        load  = !frame_start && free >= blen_c;
        state_n = frame_start ? IDLE : load ? ISSUE : SPACE;
      end
      ISSUE: begin
        flush = frame_start && !app_op_begun;
        state_n = app_op_begun ? (frame_start ? DRAIN : READ) : frame_start ? IDLE : ISSUE;
      end
      READ: begin
        // once aborted, the rest of the burst is discarded and the flush waits for op_finished
        cap   = app_data_ok && !phase && !frame_start;
        flush = frame_start && op_finished;
        state_n = frame_start ? (op_finished ? IDLE : DRAIN)
                : op_finished ? (remaining == 12'(cap) ? IDLE : SPACE) : READ;
      end
      DRAIN: begin
        flush   = op_finished;
        state_n = op_finished ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= BASE_ADDR;
      remaining <= '0;
      blen      <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      app_addr  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pix_data  <= '0;
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_n;
      phase <= state == READ && (phase ^ app_data_ok);
      if (start) remaining <= 12'(LINE_WORDS);
      if (load) begin
        app_addr <= acc;
        blen     <= blen_c;
        bcnt     <= '0;
      end
      if (cap) begin
        acc       <= acc + 23'd1;
        remaining <= remaining - 12'd1;
        bcnt      <= bcnt + 13'd1;
        wptr      <= wptr + AW'(1);
      end
      if (pop) begin
        rptr     <= rptr + AW'(1);
        pix_data <= mem[rptr];
      end
      count <= count + (AW+1)'(cap) - (AW+1)'(pop);
      if (pix_rd && count == '0) underflow <= 1'b1;
      if (line_start && !frame_start && state != IDLE) overrun <= 1'b1;
      if (flush) begin
        acc       <= BASE_ADDR;
        wptr      <= '0;
        rptr      <= '0;
        count     <= '0;
        underflow <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_100) if (cap) mem[wptr] <= app_data_out;
endmodule

// File: tb/tb_psram_line_fetch.sv
// tb_psram_line_fetch: controller model plus burst/data scoreboards for psram_line_fetch
module tb_psram_line_fetch;
  localparam int LW = 300, FD = 256, RW = 128;
  typedef struct packed {logic [22:0] addr; logic [15:0] len;} burst_t;
  logic clk_100 = 0, reset = 0, frame_start = 0, line_start = 0, pix_rd = 0;
  logic app_ctrlr_good = 1, app_op_begun = 0, app_data_ok = 0, op_finished = 0;
  logic [15:0] app_data_out = '0, pix_data;
  logic pix_empty, line_busy, underflow, overrun, app_rd, app_burst_op;
  logic [22:0] app_addr;
  burst_t obs_q[$], exp_b[$];
  logic [15:0] exp_data[$];
  logic [15:0] last_exp = '0;
  logic [22:0] next_addr = '0, m_addr;
  int checks = 0, errors = 0, budget = 0, obs_rd = 0, mdl_words = 0, m_n;
  logic chk_pend = 0, force_rd = 0, m_cont, saw_rd;

  psram_line_fetch #(.LINE_WORDS(LW), .BASE_ADDR(23'h0), .ROW_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk_100(clk_100), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_empty(pix_empty), .line_busy(line_busy),
    .underflow(underflow), .overrun(overrun), .app_ctrlr_good(app_ctrlr_good), .app_rd(app_rd),
    .app_addr(app_addr), .app_burst_op(app_burst_op), .app_op_begun(app_op_begun),
    .app_data_ok(app_data_ok), .op_finished(op_finished), .app_data_out(app_data_out));

  always #5 clk_100 = ~clk_100;

  // controller: accepts after 2 cycles, holds each word for two data_ok cycles, data = address
  always begin
    @(posedge clk_100); #1;
    if (app_rd) begin
      m_addr = app_addr;
      repeat (2) begin @(posedge clk_100); #1; end
      app_op_begun = 1; mdl_words = 0;
      @(posedge clk_100); #1;
      app_op_begun = 0; m_n = 0; m_cont = 1;
      while (m_cont && m_n < 200) begin
        app_data_ok = 1; app_data_out = 16'(m_addr + 23'(m_n));
        @(posedge clk_100); #1;
        m_n++; mdl_words = m_n; m_cont = app_burst_op;
        @(posedge clk_100); #1;
      end
      app_data_ok = 0; op_finished = 1;
      @(posedge clk_100); #1;
      op_finished = 0; mdl_words = 0;
      obs_q.push_back('{m_addr, 16'(m_n)});
    end
  end

  initial begin #800000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic tick;
    @(posedge clk_100); #1;
    if (chk_pend) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++; $display("FAIL pix_data: got %h, no word expected", pix_data);
      end else begin
        if (pix_data !== exp_data[0]) begin
          errors++; $display("FAIL pix_data: got %h, want %h", pix_data, exp_data[0]);
        end
        last_exp = exp_data.pop_front();
      end
    end
    chk_pend = 0;
    pix_rd = force_rd;
    if (budget > 0 && !pix_empty) begin pix_rd = 1; chk_pend = 1; budget--; end
  endtask

  task automatic frame;
    frame_start = 1; tick(); frame_start = 0;
    next_addr = '0; exp_b.delete(); exp_data.delete();
  endtask

  task automatic sync_model;
    repeat (8) tick();
    obs_rd = obs_q.size(); exp_b.delete(); exp_data.delete();
  endtask

  task automatic start_line;
    logic [22:0] a;
    int rem, len;
    a = next_addr; rem = LW;
    while (rem > 0) begin
      len = RW - int'(a[6:0]);
      if (len > rem) len = rem;
      exp_b.push_back('{a, 16'(len)});
      a += 23'(len); rem -= len;
    end
    for (int i = 0; i < LW; i++) exp_data.push_back(16'(next_addr + 23'(i)));
    next_addr += 23'(LW);
    line_start = 1; tick(); line_start = 0;
  endtask

  task automatic finish_line(input string tag);
    int t;
    t = 0;
    while (line_busy && t < 4000) begin tick(); t++; end
    checks++;
    if (line_busy !== 1'b0) begin errors++; $display("FAIL %s line_busy: got %b, want 0", tag, line_busy); end
    repeat (3) tick();
    while (exp_b.size() > 0) begin
      burst_t e;
      e = exp_b.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin
        errors++; $display("FAIL %s burst: got none, want addr %0d len %0d", tag, e.addr, e.len);
      end else begin
        if (obs_q[obs_rd] !== e) begin
          errors++;
          $display("FAIL %s burst: got addr %0d len %0d, want addr %0d len %0d",
                   tag, obs_q[obs_rd].addr, obs_q[obs_rd].len, e.addr, e.len);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin
      errors++; $display("FAIL %s burst count: got %0d extra, want 0", tag, obs_q.size() - obs_rd);
      obs_rd = obs_q.size();
    end
  endtask

  task automatic drain(input string tag);
    int t;
    budget = 100000; t = 0;
    while ((exp_data.size() > 0 || chk_pend) && t < 3000) begin tick(); t++; end
    budget = 0; tick();
    checks++;
    if (exp_data.size() != 0 || pix_empty !== 1'b1) begin
      errors++; $display("FAIL %s drain: got %0d left empty=%b, want 0 left empty=1", tag, exp_data.size(), pix_empty);
    end
  endtask

  task automatic test_reset;
    reset = 0; repeat (3) tick();
    checks += 2;
    if ({app_rd, app_burst_op, line_busy, underflow, overrun, pix_empty} !== 6'b000001) begin
      errors++; $display("FAIL reset flags: got %b, want 000001", {app_rd, app_burst_op, line_busy, underflow, overrun, pix_empty});
    end
    if ({app_addr, pix_data} !== 39'h0) begin
      errors++; $display("FAIL reset data: got addr %h data %h, want 0 0", app_addr, pix_data);
    end
    reset = 1; tick();
  endtask

  task automatic test_line_fetch;
    budget = 100000;
    start_line();
    checks++;
    if (line_busy !== 1'b1) begin errors++; $display("FAIL line0 busy: got %b, want 1", line_busy); end
    finish_line("line0");
    drain("line0");
  endtask

  task automatic test_row_split;
    budget = 100000;
    start_line();
    finish_line("line1");
    drain("line1");
  endtask

  task automatic test_backpressure;
    int t;
    budget = 0; frame();
    start_line();
    t = 0;
    while (obs_q.size() - obs_rd < 2 && t < 2000) begin tick(); t++; end
    saw_rd = 0;
    repeat (100) begin tick(); saw_rd |= app_rd; end
    checks += 2;
    if (obs_q.size() - obs_rd != 2 || saw_rd !== 1'b0) begin
      errors++; $display("FAIL bp full stall: got %0d bursts rd=%b, want 2 rd=0", obs_q.size() - obs_rd, saw_rd);
    end
    if (line_busy !== 1'b1 || pix_empty !== 1'b0) begin
      errors++; $display("FAIL bp busy: got busy=%b empty=%b, want 1 0", line_busy, pix_empty);
    end
    budget = 43; saw_rd = 0;
    repeat (150) begin tick(); saw_rd |= app_rd; end
    checks++;
    if (saw_rd !== 1'b0) begin errors++; $display("FAIL bp 43 free: got rd=%b, want 0", saw_rd); end
    budget = 1;
    finish_line("bp");
    drain("bp");
  endtask

  task automatic test_frame_abort;
    int t;
    budget = 0; frame();
    start_line();
    t = 0;
    while (mdl_words < 50 && t < 2000) begin tick(); t++; end
    frame();
    checks++;
    if (app_burst_op !== 1'b0) begin errors++; $display("FAIL abort burst_op: got %b, want 0", app_burst_op); end
    t = 0;
    while (line_busy && t < 50) begin tick(); t++; end
    checks++;
    if (line_busy !== 1'b0 || pix_empty !== 1'b1) begin
      errors++; $display("FAIL abort flush: got busy=%b empty=%b, want 0 1", line_busy, pix_empty);
    end
    sync_model();
    budget = 100000;
    start_line();
    finish_line("restart");
    drain("restart");
  endtask

  task automatic test_flags;
    int t;
    force_rd = 1; tick(); force_rd = 0; tick();
    checks += 2;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow set: got %b, want 1", underflow); end
    if (pix_data !== 16'd299) begin errors++; $display("FAIL underflow hold: got %h, want %h", pix_data, 16'd299); end
    budget = 100000;
    start_line();
    repeat (5) tick();
    line_start = 1; tick(); line_start = 0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun set: got %b, want 1", overrun); end
    finish_line("ovr");
    drain("ovr");
    frame();
    checks++;
    if ({underflow, overrun} !== 2'b00) begin errors++; $display("FAIL flag clear: got %b, want 00", {underflow, overrun}); end
    start_line();
    repeat (10) tick();
    line_start = 1; frame(); line_start = 0;
    t = 0;
    while (line_busy && t < 400) begin tick(); t++; end
    sync_model();
    checks++;
    if ({overrun, line_busy, pix_empty} !== 3'b001) begin
      errors++; $display("FAIL frame wins: got ovr/busy/empty %b, want 001", {overrun, line_busy, pix_empty});
    end
  endtask

  task automatic test_reset_mid;
    int t;
    budget = 0;
    start_line();
    t = 0;
    while (obs_q.size() == obs_rd && t < 1000) begin tick(); t++; end
    t = 0;
    while (mdl_words < 20 && t < 1000) begin tick(); t++; end
    checks++;
    if (app_addr !== 23'd128) begin errors++; $display("FAIL mid addr: got %0d, want 128", app_addr); end
    reset = 0; tick();
    checks += 2;
    if ({app_rd, app_burst_op, line_busy, underflow, overrun, pix_empty} !== 6'b000001) begin
      errors++; $display("FAIL mid reset flags: got %b, want 000001", {app_rd, app_burst_op, line_busy, underflow, overrun, pix_empty});
    end
    if ({app_addr, pix_data} !== 39'h0) begin
      errors++; $display("FAIL mid reset data: got addr %h data %h, want 0 0", app_addr, pix_data);
    end
    repeat (2) tick();
    reset = 1;
    sync_model(); next_addr = '0;
    app_ctrlr_good = 0; saw_rd = 0;
    line_start = 1; tick(); line_start = 0;
    repeat (50) begin tick(); saw_rd |= app_rd; end
    checks++;
    if ({saw_rd, line_busy} !== 2'b00) begin errors++; $display("FAIL not good: got rd/busy %b, want 00", {saw_rd, line_busy}); end
    app_ctrlr_good = 1;
  endtask

  initial begin
    test_reset();
    test_line_fetch();
    test_row_split();
    test_backpressure();
    test_frame_abort();
    test_flags();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
